// File: rtl/pwm_duty_control.sv
`default_nettype none
// pwm_duty_control: three debounced buttons adjust a 4-bit PWM duty (up/down) and toggle its enable.
// Define PWM_DUTY_WRAP_EN to make the duty wrap at 0/15 instead of saturating. Rev 1.0
module pwm_duty_control #(
  parameter int         DEBOUNCE_CYCLES = 16,
  parameter logic [3:0] DUTY_RESET      = 4'd8
) (
  input  logic       clock,
  input  logic       i_reset_n,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_en,
  output logic [3:0] o_valor_pwm,
  output logic       o_enable,
  output logic       o_changed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The sample that opens a check window is the first of the DEBOUNCE_CYCLES
  // consecutive samples, so the counter only needs to reach DEBOUNCE_CYCLES-2.
  localparam int LAST = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK_HI = 2'd1,
    PRESSED  = 2'd2,
    CHECK_LO = 2'd3
  } state_t;

  // Asynchronous assertion, release synchronized to clock.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [2:0] btn_raw;
  logic [2:0] press;

  assign btn_raw = {i_btn_en, i_btn_down, i_btn_up};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic [1:0]       sync;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             pulse, pulse_nx;

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        sync  <= 2'b00;
        state <= IDLE;
        cnt   <= '0;
        pulse <= 1'b0;
      end else begin
        sync  <= {sync[0], btn_raw[b]};
        state <= state_nx;
        cnt   <= cnt_nx;
        pulse <= pulse_nx;
      end
    end

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pulse_nx = 1'b0;
      case (state)
        IDLE: begin
          if (sync[1]) begin
            state_nx = CHECK_HI;
            cnt_nx   = '0;
          end
        end
        CHECK_HI: begin
          if (!sync[1]) begin
            state_nx = IDLE;
          end else if (cnt == CNT_LAST) begin
            state_nx = PRESSED;
            pulse_nx = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync[1]) begin
            state_nx = CHECK_LO;
            cnt_nx   = '0;
          end
        end
        CHECK_LO: begin
          if (sync[1]) begin
            state_nx = PRESSED;
          end else if (cnt == CNT_LAST) begin
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end

    assign press[b] = pulse;
  end

  logic [3:0] duty_nx;
  logic       duty_upd;

  // Simultaneous up and down presses cancel each other.
  always_comb begin
    duty_nx  = o_valor_pwm;
    duty_upd = 1'b0;
    if (press[0] && !press[1]) begin
`ifdef PWM_DUTY_WRAP_EN
      duty_nx  = o_valor_pwm + 4'd1;
      duty_upd = 1'b1;
`else
      if (o_valor_pwm != 4'hF) begin
        duty_nx  = o_valor_pwm + 4'd1;
        duty_upd = 1'b1;
      end
`endif
    end else if (press[1] && !press[0]) begin
`ifdef PWM_DUTY_WRAP_EN
      duty_nx  = o_valor_pwm - 4'd1;
      duty_upd = 1'b1;
`else
      if (o_valor_pwm != 4'h0) begin
        duty_nx  = o_valor_pwm - 4'd1;
        duty_upd = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      o_valor_pwm <= DUTY_RESET;
      o_enable    <= 1'b0;
      o_changed   <= 1'b0;
    end else begin
      o_valor_pwm <= duty_nx;
      if (press[2]) o_enable <= ~o_enable;
      o_changed <= duty_upd | press[2];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_control.sv
`default_nettype none
// tb_pwm_duty_control: directed and random button stimulus scored against a run-length debounce model.
module tb_pwm_duty_control;

  localparam int DEB = 4;

  logic       clock = 1'b0;
  logic       i_reset_n = 1'b1;
  logic       i_btn_up = 1'b0;
  logic       i_btn_down = 1'b0;
  logic       i_btn_en = 1'b0;
  logic [3:0] o_valor_pwm;
  logic       o_enable;
  logic       o_changed;

  pwm_duty_control #(.DEBOUNCE_CYCLES(DEB), .DUTY_RESET(4'd8)) dut (
    .clock       (clock),
    .i_reset_n   (i_reset_n),
    .i_btn_up    (i_btn_up),
    .i_btn_down  (i_btn_down),
    .i_btn_en    (i_btn_en),
    .o_valor_pwm (o_valor_pwm),
    .o_enable    (o_enable),
    .o_changed   (o_changed)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int chg_pulses = 0;
  int chg_cyc = 0;

  typedef struct {
    int         cyc;
    logic [3:0] duty;
    logic       en;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: each button's view lags the raw pin by two edges; its
  // level flips after DEB consecutive samples disagreeing with it, and a
  // rising flip acts on the outputs one edge later.
  int   m_duty = 8;
  bit   m_en = 1'b0;
  bit   lvl[3];
  int   mis[3];
  bit   s1[3];
  bit   s2[3];
  bit   pend[3];
  int   rcnt = 0;

  function automatic void m_reset();
    m_duty = 8;
    m_en   = 1'b0;
    for (int b = 0; b < 3; b++) begin
      lvl[b] = 1'b0; mis[b] = 0; s1[b] = 1'b0; s2[b] = 1'b0; pend[b] = 1'b0;
    end
    exp_q.delete();
  endfunction

  function automatic void m_step(input bit up, input bit dn, input bit en);
    bit raw[3];
    bit ch;
    bit smp;
    raw[0] = up; raw[1] = dn; raw[2] = en;
    ch = 1'b0;
    if (pend[0] != pend[1]) begin
      if (pend[0]) begin
        if (m_duty < 15) begin m_duty++; ch = 1'b1; end
`ifdef PWM_DUTY_WRAP_EN
        else begin m_duty = 0; ch = 1'b1; end
`endif
      end else begin
        if (m_duty > 0) begin m_duty--; ch = 1'b1; end
`ifdef PWM_DUTY_WRAP_EN
        else begin m_duty = 15; ch = 1'b1; end
`endif
      end
    end
    if (pend[2]) begin m_en = !m_en; ch = 1'b1; end
    if (ch) exp_q.push_back('{cyc, 4'(m_duty), m_en});
    for (int b = 0; b < 3; b++) begin
      smp   = s2[b];
      s2[b] = s1[b];
      s1[b] = raw[b];
      pend[b] = 1'b0;
      if (smp != lvl[b]) begin
        mis[b]++;
        if (mis[b] == DEB) begin
          lvl[b]  = smp;
          mis[b]  = 0;
          pend[b] = smp;
        end
      end else begin
        mis[b] = 0;
      end
    end
  endfunction

  always @(negedge i_reset_n) begin
    m_reset();
    rcnt = 0;
  end

  always @(posedge clock) begin
    cyc++;
    if (!i_reset_n) begin
      m_reset();
      rcnt = 0;
    end else if (rcnt < 2) begin
      m_reset();
      rcnt++;
    end else begin
      m_step(i_btn_up, i_btn_down, i_btn_en);
    end
  end

  // Monitor: every o_changed pulse must match the next scoreboard entry.
  always @(negedge clock) begin
    exp_t e;
    if (o_changed) begin
      chg_pulses++;
      chg_cyc = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL changed_pulse: unexpected pulse at cycle %0d duty=%0d en=%0d", cyc, o_valor_pwm, o_enable);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.duty !== o_valor_pwm || e.en !== o_enable) begin
          bad++;
          $display("FAIL changed_update: got cycle=%0d duty=%0d en=%0d expected cycle=%0d duty=%0d en=%0d",
                   cyc, o_valor_pwm, o_enable, e.cyc, e.duty, e.en);
        end
      end
    end else if (exp_q.size() != 0) begin
      total++;
      bad++;
      e = exp_q.pop_front();
      $display("FAIL changed_missing: no pulse at cycle %0d, expected duty=%0d en=%0d", cyc, e.duty, e.en);
    end
    total++;
    if (o_valor_pwm !== 4'(m_duty) || o_enable !== m_en) begin
      bad++;
      $display("FAIL state_hold: got duty=%0d en=%0d expected duty=%0d en=%0d", o_valor_pwm, o_enable, m_duty, m_en);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] m);
    {i_btn_en, i_btn_down, i_btn_up} = m;
  endtask

  task automatic press(input logic [2:0] m, input int hold, output int start_cyc);
    @(posedge clock); #2;
    drive(m);
    start_cyc = cyc;
    repeat (hold) @(posedge clock);
    #2;
    drive(3'b000);
    repeat (12) @(posedge clock);
    #2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int st;
    int d0;
    int expect_duty;
    #1 i_reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #2 i_reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #2;
    check("reset_duty", o_valor_pwm, 8);
    check("reset_enable", o_enable, 0);
    check("reset_changed", o_changed, 0);

    // Single held press: one step, one pulse, fixed latency.
    p0 = chg_pulses;
    press(3'b001, 20, st);
    check("up_duty", o_valor_pwm, 9);
    check("up_pulses", chg_pulses - p0, 1);
    check("up_latency", chg_cyc - st, 7);

    // Short glitch is rejected.
    p0 = chg_pulses;
    press(3'b001, 3, st);
    check("glitch_duty", o_valor_pwm, 9);
    check("glitch_pulses", chg_pulses - p0, 0);

    for (int i = 0; i < 6; i++) press(3'b001, 6, st);
    check("climb_duty", o_valor_pwm, 15);

    p0 = chg_pulses;
    press(3'b001, 6, st);
`ifdef PWM_DUTY_WRAP_EN
    check("top_duty", o_valor_pwm, 0);
    check("top_pulses", chg_pulses - p0, 1);
    expect_duty = 0;
`else
    check("top_duty", o_valor_pwm, 15);
    check("top_pulses", chg_pulses - p0, 0);
    expect_duty = 15;
`endif

    // Up and down together cancel.
    p0 = chg_pulses;
    press(3'b011, 10, st);
    check("cancel_duty", o_valor_pwm, expect_duty);
    check("cancel_pulses", chg_pulses - p0, 0);

    p0 = chg_pulses;
    press(3'b100, 8, st);
    check("en_first", o_enable, 1);
    press(3'b100, 8, st);
    check("en_second", o_enable, 0);
    check("en_pulses", chg_pulses - p0, 2);

    // Reset in the middle of a press is immediate; the held button then needs a full debounce.
    press(3'b100, 8, st);
    d0 = o_valor_pwm;
    @(posedge clock); #2;
    drive(3'b001);
    repeat (4) @(posedge clock);
    #3 i_reset_n = 1'b0;
    #1;
    check("midreset_duty", o_valor_pwm, 8);
    check("midreset_enable", o_enable, 0);
    check("midreset_changed", o_changed, 0);
    repeat (2) @(posedge clock);
    #2 i_reset_n = 1'b1;
    p0 = chg_pulses;
    repeat (15) @(posedge clock);
    #2 drive(3'b000);
    repeat (12) @(posedge clock);
    #2;
    check("after_reset_duty", o_valor_pwm, 9);
    check("after_reset_pulses", chg_pulses - p0, 1);
    if (d0 == 8) $display("note: duty before reset was already 8");

    // Random button activity, including overlapping presses of different lengths.
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #2;
      drive(3'($urandom_range(0, 7)));
      repeat ($urandom_range(1, 9)) @(posedge clock);
      #2;
      if ($urandom_range(0, 1) == 1) drive(3'b000);
      repeat ($urandom_range(1, 10)) @(posedge clock);
    end
    #2 drive(3'b000);
    repeat (20) @(posedge clock);
    #2;
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
